// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   fetch_valid_i/pc_i  lookup request
//   pred_*_o            registered prediction (valid, pc, target, taken)
//   res_*_i             resolved branch from the branch unit (training)
//   branch_cnt_o        resolved branches since reset, saturating
//   mispred_cnt_o       mispredictions since reset, saturating

package mmm_pkg;
    localparam int XLEN = 32;
endpackage

module branch_predictor #(
    parameter int XLEN        = mmm_pkg::XLEN,
    parameter int BTB_ENTRIES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_valid_o,
    output logic [XLEN-1:0] pred_pc_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            pred_taken_o,
    input  logic            res_valid_i,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic [XLEN-1:0] res_target_i,
    input  logic            res_taken_i,
    input  logic            res_mispredict_i,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TAG = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG-1:0]         r_tag [BTB_ENTRIES];
    logic [XLEN-1:0]        r_tgt [BTB_ENTRIES];
    logic [1:0]             r_ctr [BTB_ENTRIES];

    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    logic [IDX-1:0]  w_f_idx;
    logic [TAG-1:0]  w_f_tag;
    logic            w_f_hit;
    logic            w_f_taken;
    logic [XLEN-1:0] w_f_target;

    logic [IDX-1:0]  w_r_idx;
    logic [TAG-1:0]  w_r_tag;
    logic            w_r_hit;
    logic [1:0]      w_ctr_cur;
    logic [1:0]      w_ctr_nxt;

    assign w_f_idx = fetch_pc_i[IDX+1:2];
    assign w_f_tag = fetch_pc_i[XLEN-1:IDX+2];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    assign w_f_taken  = w_f_hit && r_ctr[w_f_idx][1];
    assign w_f_target = w_f_taken ? r_tgt[w_f_idx]
                                  : fetch_pc_i + XLEN'(4);

    assign w_r_idx   = res_pc_i[IDX+1:2];
    assign w_r_tag   = res_pc_i[XLEN-1:IDX+2];
    assign w_r_hit   = r_valid[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
    assign w_ctr_cur = r_ctr[w_r_idx];

    always_comb begin
        w_ctr_nxt = w_ctr_cur;
        if (res_taken_i) begin
            if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
        end
    end

    // Prediction register; pc/target/taken hold while no lookup is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_o  <= 1'b0;
            pred_pc_o     <= '0;
            pred_target_o <= '0;
            pred_taken_o  <= 1'b0;
        end else begin
            pred_valid_o <= fetch_valid_i;
            if (fetch_valid_i) begin
                pred_pc_o     <= fetch_pc_i;
                pred_target_o <= w_f_target;
                pred_taken_o  <= w_f_taken;
            end
        end
    end

    // Only valid bits need a reset; a cleared entry never hits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
        end else if (res_valid_i && res_taken_i && !w_r_hit) begin
            r_valid[w_r_idx] <= 1'b1;
        end
    end

    // Lookups above read these arrays before this edge's write lands,
    // so a same-index lookup sees the pre-update entry.
    always_ff @(posedge clk_i) begin
        if (!rst_i && res_valid_i) begin
            if (w_r_hit) begin
                r_ctr[w_r_idx] <= w_ctr_nxt;
                if (res_taken_i) r_tgt[w_r_idx] <= res_target_i;
            end else if (res_taken_i) begin
                r_tag[w_r_idx] <= w_r_tag;
                r_tgt[w_r_idx] <= res_target_i;
                r_ctr[w_r_idx] <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (res_valid_i) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (res_mispredict_i && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed plan plus random traffic
// checked against a table model keyed by full branch PC.

module tb_branch_predictor;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic        pred_valid_o;
    logic [31:0] pred_pc_o;
    logic [31:0] pred_target_o;
    logic        pred_taken_o;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic [31:0] res_target_i;
    logic        res_taken_i;
    logic        res_mispredict_i;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int tests = 0;
    int fails = 0;

    // Model: each slot remembers the full PC that owns it.
    bit          m_v   [N];
    logic [31:0] m_own [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    longint      m_br;
    longint      m_mis;

    bit          e_v;
    logic [31:0] e_pc;
    logic [31:0] e_tg;
    bit          e_tk;

    always #5 clk = ~clk;

    branch_predictor #(.BTB_ENTRIES(N)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_pc_i       (fetch_pc_i),
        .pred_valid_o     (pred_valid_o),
        .pred_pc_o        (pred_pc_o),
        .pred_target_o    (pred_target_o),
        .pred_taken_o     (pred_taken_o),
        .res_valid_i      (res_valid_i),
        .res_pc_i         (res_pc_i),
        .res_target_i     (res_target_i),
        .res_taken_i      (res_taken_i),
        .res_mispredict_i (res_mispredict_i),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    function automatic int midx(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic bit mhit(logic [31:0] pc);
        int i = midx(pc);
        return m_v[i] && ((m_own[i] / (4 * N)) == (pc / (4 * N)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit fv,
                        input logic [31:0] fpc, input bit rv,
                        input logic [31:0] rpc, input logic [31:0] rtg,
                        input bit rt, input bit rm);
        int i;
        @(negedge clk);
        rst_i            = rst;
        fetch_valid_i    = fv;
        fetch_pc_i       = fpc;
        res_valid_i      = rv;
        res_pc_i         = rpc;
        res_target_i     = rtg;
        res_taken_i      = rt;
        res_mispredict_i = rm;
        if (rst) begin
            e_v = 0; e_pc = 0; e_tg = 0; e_tk = 0;
            for (int k = 0; k < N; k++) m_v[k] = 0;
            m_br = 0; m_mis = 0;
        end else begin
            e_v = fv;
            if (fv) begin
                i = midx(fpc);
                e_pc = fpc;
                if (mhit(fpc) && m_ctr[i] >= 2) begin
                    e_tk = 1; e_tg = m_tgt[i];
                end else begin
                    e_tk = 0; e_tg = fpc + 32'd4;
                end
            end
            if (rv) begin
                i = midx(rpc);
                if (mhit(rpc)) begin
                    if (rt) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = rtg;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (rt) begin
                    m_v[i] = 1; m_own[i] = rpc;
                    m_tgt[i] = rtg; m_ctr[i] = 2;
                end
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (rm && m_mis < 64'hFFFF_FFFF) m_mis++;
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid", 32'(pred_valid_o), 32'(e_v));
        chk("pred_pc", pred_pc_o, e_pc);
        chk("pred_target", pred_target_o, e_tg);
        chk("pred_taken", 32'(pred_taken_o), 32'(e_tk));
        chk("branch_cnt", branch_cnt_o, 32'(m_br));
        chk("mispred_cnt", mispred_cnt_o, 32'(m_mis));
    endtask

    task automatic look(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic res(input logic [31:0] pc, input logic [31:0] tg,
                       input bit t, input bit m);
        step(0, 0, 0, 1, pc, tg, t, m);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] fpc;

        // Reset and cold lookup
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 1, 32'h100, 32'h40, 1, 1);
        chk("rst_branch_cnt", branch_cnt_o, 32'd0);
        chk("rst_pred_valid", 32'(pred_valid_o), 32'd0);
        look(32'h100);
        chk("cold_target", pred_target_o, 32'h104);
        chk("cold_taken", 32'(pred_taken_o), 32'd0);

        // Cold miss allocation
        res(32'h100, 32'h40, 1, 1);
        look(32'h100);
        chk("alloc_target", pred_target_o, 32'h40);
        chk("alloc_taken", 32'(pred_taken_o), 32'd1);
        chk("alloc_br", branch_cnt_o, 32'd1);
        chk("alloc_mis", mispred_cnt_o, 32'd1);

        // Hysteresis
        res(32'h100, 32'h40, 0, 1);
        look(32'h100);
        chk("hyst_nt", 32'(pred_taken_o), 32'd0);
        res(32'h100, 32'h44, 1, 1);
        res(32'h100, 32'h44, 1, 0);
        look(32'h100);
        chk("hyst_t3", pred_target_o, 32'h44);
        res(32'h100, 32'h44, 0, 1);
        look(32'h100);
        chk("hyst_t2", 32'(pred_taken_o), 32'd1);

        // No-allocate on not-taken miss, then alias replacement
        res(32'h200, 32'h80, 0, 0);
        look(32'h200);
        look(32'h100);
        res(32'h200, 32'h80, 1, 1);
        look(32'h100);
        chk("alias_old", pred_target_o, 32'h104);
        look(32'h200);
        chk("alias_new", pred_target_o, 32'h80);

        // Same-cycle lookup and allocating update
        step(0, 1, 32'h100, 1, 32'h100, 32'h300, 1, 1);
        chk("coll_miss", pred_target_o, 32'h104);
        look(32'h100);
        chk("coll_hit", pred_target_o, 32'h300);

        // Idle cycle holds pred fields; pc+4 wraps
        step(0, 0, 32'h500, 0, 0, 0, 0, 0);
        look(32'hFFFF_FFFC);
        chk("wrap", pred_target_o, 32'h0);

        // Counter saturation
        force dut.r_branch_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_branch_cnt;
        m_br = 64'hFFFF_FFFE;
        res(32'h104, 32'h10, 0, 0);
        res(32'h108, 32'h10, 1, 1);
        res(32'h10C, 32'h10, 0, 0);
        chk("sat_br", branch_cnt_o, 32'hFFFF_FFFF);

        // Reset dominates a concurrent update and lookup
        step(1, 1, 32'h100, 1, 32'h100, 32'h50, 1, 1);
        chk("rst2_br", branch_cnt_o, 32'd0);
        look(32'h100);
        chk("rst2_miss", pred_target_o, 32'h104);

        // Random traffic over a few indices and aliasing tags
        for (int n = 0; n < 500; n++) begin
            rpc = (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 7)) << 2);
            fpc = (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) fpc = rpc;
            step($urandom_range(0, 60) == 0,
                 $urandom_range(0, 3) != 0, fpc,
                 $urandom_range(0, 2) != 0, rpc,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
